// File: rtl/multi_mode_ff_bank.sv
// Bank of independent flip-flop channels, each run-time selectable
// as D, T, JK or SR, with change pulses and sticky SR error flags.
module multi_mode_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter int               SR_POLICY = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic [WIDTH-1:0] chg,
    output logic [WIDTH-1:0] err
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    // Any policy other than 1 or 2 falls back to hold-and-flag.
    localparam bit SR_SET_DOM = (SR_POLICY == 1);
    localparam bit SR_RST_DOM = (SR_POLICY == 2);
    localparam bit SR_FLAG    = !(SR_SET_DOM || SR_RST_DOM);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [WIDTH-1:0] err_set;

    always_comb begin
        q_d     = q_q;
        err_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (en[i]) begin
                case (mode)
                    MODE_D:  q_d[i] = a[i];
                    MODE_T:  q_d[i] = q_q[i] ^ a[i];
                    MODE_JK: begin
                        case ({a[i], b[i]})
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            2'b11:   q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    MODE_SR: begin
                        case ({a[i], b[i]})
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            2'b11: begin
                                if (SR_SET_DOM)
                                    q_d[i] = 1'b1;
                                else if (SR_RST_DOM)
                                    q_d[i] = 1'b0;
                                err_set[i] = SR_FLAG;
                            end
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
    end

    always_comb begin
        chg_d = q_d ^ q_q;
        // A fresh error on the clearing edge must survive the clear.
        err_d = (err_clr ? '0 : err_q) | err_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= RESET_VAL;
            chg_q <= '0;
            err_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            err_q <= err_d;
        end
    end

    assign Q     = q_q;
    assign Q_bar = ~q_q;
    assign chg   = chg_q;
    assign err   = err_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Bench for multi_mode_ff_bank: three instances (SR_POLICY 0/1/2)
// driven in lockstep and compared against a behavioural model.
module tb_multi_mode_ff_bank;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] en = 8'h00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       err_clr = 1'b0;

    logic [7:0] dq[3];
    logic [7:0] dqb[3];
    logic [7:0] dchg[3];
    logic [7:0] derr[3];

    logic [7:0] mq[3];
    logic [7:0] mchg[3];
    logic [7:0] merr[3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(0), .RESET_VAL(RV)) u0 (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .a(a), .b(b),
        .err_clr(err_clr), .Q(dq[0]), .Q_bar(dqb[0]), .chg(dchg[0]),
        .err(derr[0])
    );
    multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(1), .RESET_VAL(RV)) u1 (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .a(a), .b(b),
        .err_clr(err_clr), .Q(dq[1]), .Q_bar(dqb[1]), .chg(dchg[1]),
        .err(derr[1])
    );
    multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(2), .RESET_VAL(RV)) u2 (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .a(a), .b(b),
        .err_clr(err_clr), .Q(dq[2]), .Q_bar(dqb[2]), .chg(dchg[2]),
        .err(derr[2])
    );

    // Reference: apply the flip-flop rules channel by channel.
    task automatic model_update(input logic [1:0] m, input logic [7:0] e,
                                input logic [7:0] x, input logic [7:0] y,
                                input logic clr, input logic rst);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] nq;
            logic [7:0] fresh;
            if (rst) begin
                mq[k] = RV;
                mchg[k] = 8'h00;
                merr[k] = 8'h00;
            end else begin
                nq = mq[k];
                fresh = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    if (e[i]) begin
                        if (m == 2'd0) nq[i] = x[i];
                        else if (m == 2'd1) nq[i] = mq[k][i] ^ x[i];
                        else if (m == 2'd2) begin
                            if (x[i] && y[i]) nq[i] = !mq[k][i];
                            else if (x[i]) nq[i] = 1'b1;
                            else if (y[i]) nq[i] = 1'b0;
                        end else begin
                            if (x[i] && y[i]) begin
                                if (k == 1) nq[i] = 1'b1;
                                else if (k == 2) nq[i] = 1'b0;
                                else fresh[i] = 1'b1;
                            end else if (x[i]) nq[i] = 1'b1;
                            else if (y[i]) nq[i] = 1'b0;
                        end
                    end
                end
                mchg[k] = nq ^ mq[k];
                merr[k] = (clr ? 8'h00 : merr[k]) | fresh;
                mq[k] = nq;
            end
        end
    endtask

    task automatic cyc(input logic [1:0] m, input logic [7:0] e,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic clr, input logic rst);
        mode = m;
        en = e;
        a = x;
        b = y;
        err_clr = clr;
        reset = rst;
        @(posedge clk);
        model_update(m, e, x, y, clr, rst);
        #1;
    endtask

    task automatic test_reset;
        cyc(2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        cyc(2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dq[k] !== 8'hA5 || dqb[k] !== 8'h5A ||
                dchg[k] !== 8'h00 || derr[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset inst%0d: Q=%h Qb=%h chg=%h err=%h, want A5 5A 00 00",
                         k, dq[k], dqb[k], dchg[k], derr[k]);
            end
        end
        cyc(2'd1, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (dq[0] !== 8'hA5 || dchg[0] !== 8'h00) begin
            errors++;
            $display("FAIL release_hold: Q=%h chg=%h, want A5 00", dq[0], dchg[0]);
        end
    endtask

    task automatic test_d_t;
        cyc(2'd0, 8'hFF, 8'h3C, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dq[0] !== 8'h3C || dchg[0] !== 8'h99 || dqb[0] !== 8'hC3) begin
            errors++;
            $display("FAIL d_mode: Q=%h chg=%h Qb=%h, want 3C 99 C3",
                     dq[0], dchg[0], dqb[0]);
        end
        cyc(2'd1, 8'hFF, 8'h0F, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dq[0] !== 8'h33 || dchg[0] !== 8'h0F) begin
            errors++;
            $display("FAIL t_mode1: Q=%h chg=%h, want 33 0F", dq[0], dchg[0]);
        end
        cyc(2'd1, 8'hFF, 8'h0F, 8'h00, 1'b0, 1'b0);
        checks++;
        if (dq[0] !== 8'h3C) begin
            errors++;
            $display("FAIL t_mode2: Q=%h, want 3C", dq[0]);
        end
    endtask

    task automatic test_jk;
        logic [1:0] jk[4];
        logic [3:0] want_q;
        jk[0] = 2'b10;
        jk[1] = 2'b11;
        jk[2] = 2'b11;
        jk[3] = 2'b01;
        want_q = 4'b0101;
        cyc(2'd0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            cyc(2'd2, 8'hFF, {7'd0, jk[s][1]}, {7'd0, jk[s][0]}, 1'b0, 1'b0);
            checks++;
            if (dq[0][0] !== want_q[s] || dchg[0][0] !== 1'b1 ||
                dq[0][7:1] !== 7'd0) begin
                errors++;
                $display("FAIL jk_step%0d: Q=%h chg0=%b, want Q0=%b chg0=1",
                         s, dq[0], dchg[0][0], want_q[s]);
            end
        end
    endtask

    task automatic test_sr;
        cyc(2'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
        cyc(2'd3, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
        checks++;
        if (dq[0][0] !== 1'b1 || derr[0] !== 8'h01) begin
            errors++;
            $display("FAIL sr_pol0: Q0=%b err=%h, want 1 01", dq[0][0], derr[0]);
        end
        checks++;
        if (dq[1][0] !== 1'b1 || derr[1] !== 8'h00) begin
            errors++;
            $display("FAIL sr_pol1: Q0=%b err=%h, want 1 00", dq[1][0], derr[1]);
        end
        checks++;
        if (dq[2][0] !== 1'b0 || derr[2] !== 8'h00 || dchg[2][0] !== 1'b1) begin
            errors++;
            $display("FAIL sr_pol2: Q0=%b err=%h chg0=%b, want 0 00 1",
                     dq[2][0], derr[2], dchg[2][0]);
        end
        for (int s = 0; s < 3; s++) begin
            cyc(2'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
            checks++;
            if (derr[0] !== 8'h01 || dq[0][0] !== 1'b1) begin
                errors++;
                $display("FAIL sr_sticky%0d: err=%h Q0=%b, want 01 1",
                         s, derr[0], dq[0][0]);
            end
        end
    endtask

    task automatic test_err_clr;
        cyc(2'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        checks++;
        if (derr[0] !== 8'h00) begin
            errors++;
            $display("FAIL err_clr: err=%h, want 00", derr[0]);
        end
        cyc(2'd3, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
        cyc(2'd3, 8'h04, 8'h04, 8'h04, 1'b1, 1'b0);
        checks++;
        if (derr[0] !== 8'h04) begin
            errors++;
            $display("FAIL err_collide: err=%h, want 04", derr[0]);
        end
    endtask

    task automatic test_enable_reset;
        logic [7:0] prev;
        for (int s = 0; s < 4; s++) begin
            prev = dq[0];
            cyc(2'd1, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
            checks++;
            if (dq[0] !== (prev ^ 8'h01) || dchg[0] !== 8'h01) begin
                errors++;
                $display("FAIL en_gate%0d: Q=%h chg=%h, want %h 01",
                         s, dq[0], dchg[0], prev ^ 8'h01);
            end
        end
        cyc(2'd1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dq[k] !== RV || dchg[k] !== 8'h00 || derr[k] !== 8'h00) begin
                errors++;
                $display("FAIL mid_reset inst%0d: Q=%h chg=%h err=%h, want A5 00 00",
                         k, dq[k], dchg[k], derr[k]);
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            cyc(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                8'($urandom), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 49) == 0));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dq[k] !== mq[k] || dqb[k] !== ~mq[k] ||
                    dchg[k] !== mchg[k] || derr[k] !== merr[k]) begin
                    errors++;
                    $display("FAIL rand%0d inst%0d: Q=%h Qb=%h chg=%h err=%h, want %h %h %h %h",
                             n, k, dq[k], dqb[k], dchg[k], derr[k],
                             mq[k], ~mq[k], mchg[k], merr[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mq[k] = RV;
            mchg[k] = 8'h00;
            merr[k] = 8'h00;
        end
        #2;
        test_reset();
        test_d_t();
        test_jk();
        test_sr();
        test_err_clr();
        test_enable_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
